// File: rtl/pdm_sample_sched.sv
// pdm_sample_sched
// Sample-rate scheduler and two-source arbiter feeding second_order_dac.
// A free-running divider produces one sample tick every CLK_DIV clocks. On
// each tick the FSM fetches one sample from the active source. It then
// applies a click-free gain ramp and registers the offset-binary result
// on o_func.
//
// Ports:
//   i_clk          system clock
//   i_res          asynchronous active-low reset (synchronous release expected)
//   i_ce           divider enable; low freezes the divider, an in-flight fetch completes
//   i_sel          requested source (0/1), sampled only in SCALE
//   i_mute         ramp output to midscale while high, sampled only in SCALE
//   o_req[1:0]     one-hot, one-cycle fetch request to the active source
//   i_valid0/1     source sample valid
//   i_data0/1      source sample (offset-binary, W bits)
//   o_func         DAC sample (registered)
//   o_sample_tick  one-cycle pulse in the cycle o_func takes a new value
//   o_active_src   source currently being fetched
//   o_underrun     one-cycle pulse when a fetch timed out
//   o_underrun_cnt saturating count of timed-out fetches
//
// Optional build macro: PDM_SCHED_DITHER_EN adds a +/-8 LSB LFSR dither to
// the scaled sample, with saturation to 0..2^W-1.
//
// Handshake: o_req[k] is high for exactly one cycle (state REQ). From the
// next cycle on, the first cycle with i_valid<k> high transfers i_data<k>.
// A source that is not being waited on may toggle its valid freely. The
// same holds for the active source during the REQ cycle itself. If no
// valid arrives within TIMEOUT cycles, the previous sample is reused.
//
// FSM state is held in r_state (type state_t) for observation.

module pdm_sample_sched #(
  parameter int W         = 16,
  parameter int CLK_DIV   = 1000,
  parameter int TIMEOUT   = 64,
  parameter int RAMP_STEP = 8
) (
  input  logic         i_clk,
  input  logic         i_res,
  input  logic         i_ce,
  input  logic         i_sel,
  input  logic         i_mute,
  output logic [1:0]   o_req,
  input  logic         i_valid0,
  input  logic [W-1:0] i_data0,
  input  logic         i_valid1,
  input  logic [W-1:0] i_data1,
  output logic [W-1:0] o_func,
  output logic         o_sample_tick,
  output logic         o_active_src,
  output logic         o_underrun,
  output logic [7:0]   o_underrun_cnt
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
  localparam logic [W-1:0]     MID      = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W+1:0] MID_X = {2'b00, MID};
  localparam logic [8:0]       GAIN_MAX = 9'd256;
  localparam logic [9:0]       STEP     = 10'(RAMP_STEP);

  typedef enum logic [1:0] {
    S_WAIT_TICK = 2'd0,
    S_REQ       = 2'd1,
    S_WAIT_DATA = 2'd2,
    S_SCALE     = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [DIV_W-1:0] r_div;
  logic [TO_W-1:0]  r_wait;
  logic [W-1:0]     r_last;
  logic [8:0]       r_gain;
  logic             r_active;
  logic [W-1:0]     r_func;
  logic             r_tick;
  logic             r_underrun;
  logic [7:0]       r_ucnt;

  logic             w_tick;
  logic             w_valid_act;
  logic [W-1:0]     w_data_act;
  logic             w_timeout;
  logic [8:0]       w_target;
  logic [9:0]       w_gain_up;
  logic [8:0]       w_gain_new;
  logic             w_switch;

  logic signed [W:0]    w_diff;
  logic signed [W+10:0] w_diff_x;
  logic signed [W+10:0] w_gain_x;
  logic signed [W+10:0] w_prod;
  logic signed [W+10:0] w_shift;
  logic signed [W+1:0]  w_shift_t;
  logic signed [W+1:0]  w_sum;
  logic [W-1:0]         w_func_next;
  logic                 w_unused;

  // ---------------------------------------------------------------------
  // Sample-rate divider. A tick that lands outside WAIT_TICK is dropped.
  // ---------------------------------------------------------------------
  assign w_tick = i_ce && (r_div == DIV_LAST);

  always_ff @(posedge i_clk or negedge i_res) begin
    if (!i_res) begin
      r_div <= '0;
    end else if (i_ce) begin
      r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_ONE;
    end
  end

  // ---------------------------------------------------------------------
  // Fetch FSM
  // ---------------------------------------------------------------------
  assign w_valid_act = r_active ? i_valid1 : i_valid0;
  assign w_data_act  = r_active ? i_data1  : i_data0;
  assign w_timeout   = (r_wait == TO_LAST);

  always_ff @(posedge i_clk or negedge i_res) begin
    if (!i_res) r_state <= S_WAIT_TICK;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    o_req        = 2'b00;
    case (r_state)
      S_WAIT_TICK: if (w_tick) w_state_next = S_REQ;
      S_REQ: begin
        o_req        = r_active ? 2'b10 : 2'b01;
        w_state_next = S_WAIT_DATA;
      end
      // A valid in the final wait cycle still wins over the timeout.
      S_WAIT_DATA: if (w_valid_act || w_timeout) w_state_next = S_SCALE;
      S_SCALE:     w_state_next = S_WAIT_TICK;
      default:     w_state_next = S_WAIT_TICK;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_res) begin
    if (!i_res) begin
      r_wait     <= '0;
      r_last     <= MID;
      r_underrun <= 1'b0;
      r_ucnt     <= 8'd0;
    end else begin
      r_underrun <= 1'b0;
      if (r_state == S_REQ) begin
        r_wait <= '0;
      end else if (r_state == S_WAIT_DATA) begin
        if (w_valid_act) begin
          r_last <= w_data_act;
        end else if (w_timeout) begin
          r_underrun <= 1'b1;
          if (r_ucnt != 8'hFF) r_ucnt <= r_ucnt + 8'd1;
        end else begin
          r_wait <= r_wait + TO_ONE;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Gain ramp. The target is 0 while muted or while a different source is
  // requested. The source only changes once the output has faded to 0.
  // ---------------------------------------------------------------------
  assign w_target  = (i_mute || (i_sel != r_active)) ? 9'd0 : GAIN_MAX;
  assign w_gain_up = {1'b0, r_gain} + STEP;

  always_comb begin
    w_gain_new = r_gain;
    if (r_gain < w_target) begin
      w_gain_new = (w_gain_up > {1'b0, GAIN_MAX}) ? GAIN_MAX : w_gain_up[8:0];
    end else if (r_gain > w_target) begin
      w_gain_new = ({1'b0, r_gain} <= STEP) ? 9'd0 : (r_gain - STEP[8:0]);
    end
  end

  assign w_switch = (w_gain_new == 9'd0) && (i_sel != r_active);

  // ---------------------------------------------------------------------
  // Scaling around midscale. The signed difference is multiplied by the
  // gain (0..256) and shifted right by 8. Gain 256 is therefore an exact
  // passthrough.
  // ---------------------------------------------------------------------
  assign w_diff    = $signed({1'b0, r_last}) - $signed({1'b0, MID});
  assign w_diff_x  = {{10{w_diff[W]}}, w_diff};
  assign w_gain_x  = {{(W+2){1'b0}}, w_gain_new};
  assign w_prod    = w_diff_x * w_gain_x;
  assign w_shift   = w_prod >>> 8;
  assign w_shift_t = w_shift[W+1:0];
  assign w_sum     = MID_X + w_shift_t;

`ifdef PDM_SCHED_DITHER_EN
  localparam logic signed [W+1:0] DITH_OFS = (W+2)'(8);

  logic [15:0]         r_lfsr;
  logic signed [W+1:0] w_dith;
  logic signed [W+1:0] w_sum_d;

  // Galois LFSR (taps 0xB400), advanced once per produced sample.
  always_ff @(posedge i_clk or negedge i_res) begin
    if (!i_res) begin
      r_lfsr <= 16'hACE1;
    end else if (r_state == S_SCALE) begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  // lfsr[3:0] - 8 spans -8..+7.
  assign w_dith  = {{(W-2){1'b0}}, r_lfsr[3:0]} - DITH_OFS;
  assign w_sum_d = w_sum + w_dith;

  always_comb begin
    if (w_sum_d[W+1])   w_func_next = '0;
    else if (w_sum_d[W]) w_func_next = '1;
    else                w_func_next = w_sum_d[W-1:0];
  end
`else
  assign w_func_next = w_sum[W-1:0];
`endif

  // The upper product bits are always sign copies for a gain of 256 or less.
  assign w_unused = ^{w_shift[W+10:W+2], w_sum[W+1:W]};

  always_ff @(posedge i_clk or negedge i_res) begin
    if (!i_res) begin
      r_gain   <= 9'd0;
      r_active <= 1'b0;
      r_func   <= MID;
      r_tick   <= 1'b0;
    end else begin
      r_tick <= (r_state == S_SCALE);
      if (r_state == S_SCALE) begin
        r_gain <= w_gain_new;
        r_func <= w_func_next;
        if (w_switch) r_active <= i_sel;
      end
    end
  end

  assign o_func         = r_func;
  assign o_sample_tick  = r_tick;
  assign o_active_src   = r_active;
  assign o_underrun     = r_underrun;
  assign o_underrun_cnt = r_ucnt;

endmodule

// File: tb/tb_pdm_sample_sched.sv
// Testbench for pdm_sample_sched with CLK_DIV=16, TIMEOUT=8, RAMP_STEP=8.
// A responder answers each o_req one cycle later. It also injects ignored
// valids: one from the active source in the REQ cycle, and one from the
// inactive source. A reference model pushes the expected o_func,
// o_active_src and o_underrun_cnt values when a request is issued. The
// monitor pops and compares them on every o_sample_tick.

module tb_pdm_sample_sched;

  localparam int W         = 16;
  localparam int CLK_DIV   = 16;
  localparam int TIMEOUT   = 8;
  localparam int RAMP_STEP = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         i_res;
  logic         i_ce;
  logic         i_sel;
  logic         i_mute;
  logic [1:0]   o_req;
  logic [1:0]   v;
  logic [W-1:0] d0;
  logic [W-1:0] d1;
  logic [W-1:0] o_func;
  logic         o_sample_tick;
  logic         o_active_src;
  logic         o_underrun;
  logic [7:0]   o_underrun_cnt;

  pdm_sample_sched #(
    .W(W), .CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT), .RAMP_STEP(RAMP_STEP)
  ) dut (
    .i_clk(clk),
    .i_res(i_res),
    .i_ce(i_ce),
    .i_sel(i_sel),
    .i_mute(i_mute),
    .o_req(o_req),
    .i_valid0(v[0]),
    .i_data0(d0),
    .i_valid1(v[1]),
    .i_data1(d1),
    .o_func(o_func),
    .o_sample_tick(o_sample_tick),
    .o_active_src(o_active_src),
    .o_underrun(o_underrun),
    .o_underrun_cnt(o_underrun_cnt)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic         act_q[$];
  logic [7:0]   cnt_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int tick_cnt = 0;
  int und_seen = 0;
  int und_exp  = 0;
  int cyc      = 0;
  int last_req_cyc = 0;
  int gap_exp  = CLK_DIV;
  bit last_req_ok = 1'b0;

  logic [W-1:0] src_val [2];
  logic         resp_en [2];

  // reference model state
  int   m_gain   = 0;
  int   m_last   = 32768;
  int   m_cnt    = 0;
  logic m_active = 1'b0;
  logic m_k;
  int   m_tgt;
  int   m_exp;

  always @(posedge clk) cyc <= cyc + 1;

  // model + responder: runs on every observed request
  initial forever begin
    @(negedge clk);
    if (i_res === 1'b1 && o_req !== 2'b00) begin
      n_checks++;
      if (o_req !== (m_active ? 2'b10 : 2'b01))
        $display("FAIL req_onehot: got %b want %b", o_req, (m_active ? 2'b10 : 2'b01));
      else n_pass++;
      if (last_req_ok) begin
        n_checks++;
        if (cyc - last_req_cyc != gap_exp)
          $display("FAIL req_period: got %0d want %0d", cyc - last_req_cyc, gap_exp);
        else n_pass++;
      end
      gap_exp      = CLK_DIV;
      last_req_cyc = cyc;
      last_req_ok  = 1'b1;

      m_k = m_active;
      if (resp_en[m_k]) m_last = int'(src_val[m_k]);
      else begin
        if (m_cnt < 255) m_cnt++;
        und_exp++;
      end
      m_tgt = (i_mute || (i_sel != m_active)) ? 0 : 256;
      if (m_gain < m_tgt)      m_gain = (m_gain + RAMP_STEP > 256) ? 256 : m_gain + RAMP_STEP;
      else if (m_gain > m_tgt) m_gain = (m_gain < RAMP_STEP) ? 0 : m_gain - RAMP_STEP;
      m_exp = 32768 + (((m_last - 32768) * m_gain) >>> 8);
      if (m_gain == 0 && i_sel != m_active) m_active = i_sel;
      exp_q.push_back(m_exp[W-1:0]);
      act_q.push_back(m_active);
      cnt_q.push_back(m_cnt[7:0]);

      // REQ cycle: junk valid that must be ignored
      v[m_k] = 1'b1;
      if (m_k) d1 = 16'h0F0F; else d0 = 16'h0F0F;
      @(posedge clk); #1;
      v[m_k]  = resp_en[m_k];
      v[!m_k] = 1'b1;
      if (m_k) begin d1 = src_val[1]; d0 = 16'h1234; end
      else     begin d0 = src_val[0]; d1 = 16'h1234; end
      @(posedge clk); #1;
      v = 2'b00;
    end
  end

  // monitor
  always @(negedge clk) begin
    if (i_res === 1'b1 && o_underrun === 1'b1) und_seen++;
    if (i_res === 1'b1 && o_sample_tick === 1'b1) begin
      tick_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_tick: got o_func %h want no tick", o_func);
      end else begin : cmp
        logic [W-1:0] e;
        logic         ea;
        logic [7:0]   ec;
        e  = exp_q.pop_front();
        ea = act_q.pop_front();
        ec = cnt_q.pop_front();
        n_checks++;
`ifdef PDM_SCHED_DITHER_EN
        begin : rng
          int lo, hi;
          lo = (int'(e) >= 8) ? int'(e) - 8 : 0;
          hi = (int'(e) + 7 > 65535) ? 65535 : int'(e) + 7;
          if (int'(o_func) < lo || int'(o_func) > hi)
            $display("FAIL func_dither: got %h want %h..%h", o_func, lo[15:0], hi[15:0]);
          else n_pass++;
        end
`else
        if (o_func !== e) $display("FAIL func: got %h want %h", o_func, e);
        else n_pass++;
`endif
        n_checks++;
        if (o_active_src !== ea) $display("FAIL active_src: got %b want %b", o_active_src, ea);
        else n_pass++;
        n_checks++;
        if (o_underrun_cnt !== ec) $display("FAIL underrun_cnt: got %0d want %0d", o_underrun_cnt, ec);
        else n_pass++;
      end
    end
  end

  // driver tasks
  task automatic wait_ticks(input int n);
    int tgt;
    int budget;
    tgt    = tick_cnt + n;
    budget = n * CLK_DIV * 2 + 200;
    while (tick_cnt < tgt && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_checks++;
    if (tick_cnt < tgt) $display("FAIL wait_ticks: got %0d ticks want %0d", tick_cnt, tgt);
    else n_pass++;
  endtask

  task automatic test_reset();
    i_res = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (o_func !== 16'h8000) $display("FAIL rst_func: got %h want 8000", o_func); else n_pass++;
    n_checks++; if (o_req !== 2'b00) $display("FAIL rst_req: got %b want 00", o_req); else n_pass++;
    n_checks++; if (o_sample_tick !== 1'b0) $display("FAIL rst_tick: got %b want 0", o_sample_tick); else n_pass++;
    n_checks++; if (o_underrun !== 1'b0) $display("FAIL rst_underrun: got %b want 0", o_underrun); else n_pass++;
    n_checks++; if (o_underrun_cnt !== 8'd0) $display("FAIL rst_cnt: got %0d want 0", o_underrun_cnt); else n_pass++;
    n_checks++; if (o_active_src !== 1'b0) $display("FAIL rst_active: got %b want 0", o_active_src); else n_pass++;
    @(negedge clk);
    i_res = 1'b1;
  endtask

  task automatic test_fade_in();
    wait_ticks(1);
    n_checks++; if (o_func !== 16'h8200) $display("FAIL fade_first: got %h want 8200", o_func); else n_pass++;
    wait_ticks(33);
    n_checks++; if (o_func !== 16'hC000) $display("FAIL fade_final: got %h want C000", o_func); else n_pass++;
  endtask

`ifdef PDM_SCHED_DITHER_EN
  task automatic test_dither();
    src_val[0] = 16'h8000;
    wait_ticks(10);
    src_val[0] = 16'hFFFF;
    wait_ticks(20);
    n_checks++; if (o_func < 16'hFFF7) $display("FAIL dither_sat: got %h want >= FFF7", o_func); else n_pass++;
    src_val[0] = 16'hC000;
    wait_ticks(2);
  endtask
`endif

  task automatic test_ce();
    int t0;
    @(posedge clk); #1;
    gap_exp = CLK_DIV + 20;
    i_ce    = 1'b0;
    t0      = tick_cnt;
    repeat (20) @(posedge clk);
    #1;
    i_ce = 1'b1;
    n_checks++;
    if (tick_cnt - t0 > 1) $display("FAIL ce_hold: got %0d ticks want <= 1", tick_cnt - t0);
    else n_pass++;
    wait_ticks(3);
  endtask

  task automatic test_mute();
    i_mute = 1'b1;
    wait_ticks(40);
    n_checks++; if (o_func !== 16'h8000) $display("FAIL mute_hold: got %h want 8000", o_func); else n_pass++;
    n_checks++; if (o_active_src !== 1'b0) $display("FAIL mute_active: got %b want 0", o_active_src); else n_pass++;
    i_mute = 1'b0;
    wait_ticks(32);
    n_checks++; if (o_func !== 16'hC000) $display("FAIL mute_release: got %h want C000", o_func); else n_pass++;
  endtask

  task automatic test_switch();
    src_val[1] = 16'h4000;
    i_sel      = 1'b1;
    wait_ticks(66);
    n_checks++; if (o_func !== 16'h4000) $display("FAIL switch_func: got %h want 4000", o_func); else n_pass++;
    n_checks++; if (o_active_src !== 1'b1) $display("FAIL switch_active: got %b want 1", o_active_src); else n_pass++;
  endtask

  task automatic test_reversal();
    i_sel = 1'b0;
    wait_ticks(5);
    i_sel = 1'b1;
    wait_ticks(6);
    n_checks++; if (o_active_src !== 1'b1) $display("FAIL rev_active: got %b want 1", o_active_src); else n_pass++;
    n_checks++; if (o_func !== 16'h4000) $display("FAIL rev_func: got %h want 4000", o_func); else n_pass++;
  endtask

  task automatic test_switch_back();
    i_sel = 1'b0;
    wait_ticks(66);
    n_checks++; if (o_func !== 16'hC000) $display("FAIL back_func: got %h want C000", o_func); else n_pass++;
    n_checks++; if (o_active_src !== 1'b0) $display("FAIL back_active: got %b want 0", o_active_src); else n_pass++;
  endtask

  task automatic test_underrun();
    resp_en[0] = 1'b0;
    wait_ticks(260);
    n_checks++; if (o_underrun_cnt !== 8'd255) $display("FAIL und_sat: got %0d want 255", o_underrun_cnt); else n_pass++;
    n_checks++; if (und_seen !== und_exp) $display("FAIL und_pulses: got %0d want %0d", und_seen, und_exp); else n_pass++;
    n_checks++; if (o_func !== 16'hC000) $display("FAIL und_hold: got %h want C000", o_func); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int budget;
    budget = 3 * CLK_DIV;
    while (o_req === 2'b00 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_checks++;
    if (budget == 0) $display("FAIL mid_req_wait: got no request want one within %0d cycles", 3 * CLK_DIV);
    else n_pass++;
    @(posedge clk);
    @(posedge clk);
    #1;
    i_res = 1'b0;
    #1;
    n_checks++; if (o_func !== 16'h8000) $display("FAIL mid_rst_func: got %h want 8000", o_func); else n_pass++;
    n_checks++; if (o_req !== 2'b00) $display("FAIL mid_rst_req: got %b want 00", o_req); else n_pass++;
    n_checks++; if (o_underrun_cnt !== 8'd0) $display("FAIL mid_rst_cnt: got %0d want 0", o_underrun_cnt); else n_pass++;
    repeat (5) @(posedge clk);
    exp_q.delete();
    act_q.delete();
    cnt_q.delete();
    m_gain = 0; m_last = 32768; m_cnt = 0; m_active = 1'b0;
    und_seen = 0; und_exp = 0;
    last_req_ok = 1'b0;
    resp_en[0] = 1'b1;
    @(negedge clk);
    i_res = 1'b1;
    wait_ticks(1);
    n_checks++; if (o_func !== 16'h8200) $display("FAIL mid_fade_restart: got %h want 8200", o_func); else n_pass++;
    wait_ticks(33);
    n_checks++; if (o_func !== 16'hC000) $display("FAIL mid_fade_final: got %h want C000", o_func); else n_pass++;
  endtask

  initial begin
    i_res = 1'b0; i_ce = 1'b1; i_sel = 1'b0; i_mute = 1'b0;
    v = 2'b00; d0 = '0; d1 = '0;
    src_val[0] = 16'hC000; src_val[1] = 16'h4000;
    resp_en[0] = 1'b1;     resp_en[1] = 1'b1;
    test_reset();
    test_fade_in();
`ifdef PDM_SCHED_DITHER_EN
    test_dither();
`endif
    test_ce();
    test_mute();
    test_switch();
    test_reversal();
    test_switch_back();
    test_underrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pdm_sample_sched.md
Name: pdm_sample_sched

Overview:
- Sample-rate scheduler and source arbiter in front of second_order_dac.
- Generates the audio sample tick from the system clock and fetches one sample per tick from one of two requesters (tone generator / stream) via a req/valid handshake.
- Applies a click-free gain ramp on source switch and mute.
- Drives the DAC's offset-binary i_func input.

Parameters:
- W, 16, sample width (offset-binary, midscale = 1<<(W-1)).
- CLK_DIV, 1000, clocks per sample tick (48 MHz / 48 kHz).
- TIMEOUT, 64, max cycles to wait for i_valid after request; legal only if TIMEOUT <= CLK_DIV-4.
- RAMP_STEP, 8, gain increment/decrement per tick (gain range 0..256).

Ports:
- i_clk  in  1  system clock
- i_res  in  1  asynchronous active-low reset
- i_ce  in  1  tick divider enable; low holds divider, in-flight fetch completes
- i_sel  in  1  requested source (0/1)
- i_mute  in  1  ramp output to midscale while high
- o_req  out  2  one-hot one-cycle fetch request to active source
- i_valid0  in  1  source 0 sample valid
- i_data0  in  W  source 0 sample
- i_valid1  in  1  source 1 sample valid
- i_data1  in  W  source 1 sample
- o_func  out  W  DAC sample (registered)
- o_sample_tick  out  1  one-cycle pulse, same cycle o_func updates
- o_active_src  out  1  source currently being fetched
- o_underrun  out  1  one-cycle pulse on fetch timeout
- o_underrun_cnt  out  8  saturating underrun count

Behaviour:
- Reset (async assert, sync release) values:
  - o_func = midscale (0x8000).
  - o_req, o_sample_tick, o_underrun = 0; o_underrun_cnt = 0; o_active_src = 0.
  - gain = 0, last_sample = midscale, divider = 0, FSM = WAIT_TICK.
- Divider: counts 0..CLK_DIV-1 while i_ce; tick on wrap. Ticks outside WAIT_TICK are dropped (impossible under the TIMEOUT constraint).
- FSM:
  - WAIT_TICK: on tick -> REQ.
  - REQ (1 cycle): o_req[active] = 1, wait counter cleared -> WAIT_DATA.
  - WAIT_DATA:
    - i_valid of active source -> latch data into last_sample -> SCALE.
    - Valid in the REQ cycle and valid of the inactive source are ignored.
    - Counter reaches TIMEOUT without valid -> o_underrun pulse, cnt+1 (saturating at 255), last_sample reused -> SCALE.
  - SCALE (1 cycle):
    - Gain update: target = 0 if i_mute or i_sel != active, else 256. Gain steps toward target by RAMP_STEP, clamped to 0..256.
    - If the new gain == 0 and i_sel != active, active flips; the next tick fetches the new source.
    - o_func <= midscale + ((last_sample - midscale) * gain_new) >>> 8. Signed W+1-bit difference, arithmetic shift, result truncated to W.
    - o_sample_tick pulses in the cycle o_func takes the new value -> WAIT_TICK.
- Latency: valid at cycle V -> o_func / o_sample_tick at V+2. Tick to o_req: 1 cycle.
- Selection and mute:
  - i_sel/i_mute are sampled only in SCALE.
  - Toggling i_sel back before gain reaches 0 reverses the ramp with no switch.
  - Mute and switch together: ramp to 0 and switch; stay at 0 while muted.
- Gain = 256 gives exact passthrough.

Optional Feature:
- Macro PDM_SCHED_DITHER_EN.
- Defined:
  - 16-bit Galois LFSR (taps 0xB400, seed 0xACE1 on reset) advances once per SCALE.
  - Signed value lfsr[3:0]-8 (range -8..+7) is added to the scaled result before the o_func register.
  - Result saturates to 0..2^W-1.
- Undefined: no LFSR, no addition, behaviour exactly as above.

Test Plan:
- Reset release, CLK_DIV=16, src0 returns 0xC000 one cycle after req -> o_func sequence 0x8200, 0x8400, ... reaching 0xC000 on tick 32 and holding; o_req[0] pulses every 16 cycles.
- Steady at 0xC000, set i_sel=1 with src1 = 0x4000 -> ramp down to 0x8000 over 32 ticks, o_active_src flips, o_req[1] on the next tick, ramp to 0x4000 over 32 ticks.
- src0 never asserts valid -> o_underrun after TIMEOUT wait cycles, o_func repeats the last value, cnt increments per tick and saturates at 255.
- i_mute high for 40 ticks mid-stream -> o_func reaches 0x8000 and holds; after release, ramps back to 0xC000 in 32 ticks.
- Assert i_res mid WAIT_DATA -> o_func = 0x8000 and o_req = 0 immediately, without waiting for a clock edge; after release, fade-in restarts from gain 0.
- With PDM_SCHED_DITHER_EN, full gain: input 0x8000 -> o_func within 0x7FF8..0x8007; input 0xFFFF -> o_func never wraps, max 0xFFFF.
